masku_result_packer: RTL

MASKU_RESULT_PACKER -- requirements
Module: masku_result_packer

---
 rtl/masku_result_packer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/masku_result_packer.sv
// Mask-unit result packer: gathers compressed mask beats into one VRF word
// and emits it with a byte strobe. The word is closed when it is full or vl runs out.
package masku_result_packer_pkg;
    typedef logic [15:0] vlen_t;
    typedef enum logic [1:0] {EW8 = 2'd0, EW16 = 2'd1, EW32 = 2'd2, EW64 = 2'd3} vew_e;
endpackage

module masku_result_packer
    import masku_result_packer_pkg::*;
#(
    parameter  int unsigned NrLanes = 4,
    localparam int unsigned ELEN    = 64,
    localparam int unsigned W       = NrLanes * ELEN,
    localparam int unsigned PntW    = $clog2(W) + 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  vlen_t             vl_i,
    input  vew_e              vsew_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [W-1:0]      in_bits_i,
    input  logic [W-1:0]      in_be_i,
    output logic [PntW-1:0]   vrf_pnt_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [W-1:0]      out_data_o,
    output logic [W/8-1:0]    out_strb_o,
    output logic              busy_o,
    output logic              done_o
);

    typedef enum logic [1:0] {IDLE, ACCUM, FLUSH} state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    acc_q, acc_d;
    logic [W/8-1:0]  strb_q, strb_d;
    logic [PntW-1:0] pnt_q, pnt_d;
    vlen_t           rem_q, rem_d;
    vew_e            vsew_q, vsew_d;
    logic            zero_done_q, zero_done_d;

    logic [W/8-1:0]  be_bytes;
    logic [1:0]      beat_shift;
    logic [PntW-1:0] beat_bits;
    logic [PntW-1:0] pnt_after;
    vlen_t           rem_step;
    vlen_t           rem_after;
    logic            flush_done;

    always_comb begin
        be_bytes = '0;
        for (int k = 0; k < W / 8; k++) begin
            be_bytes[k] = |in_be_i[8*k +: 8];
        end
    end

    // Beat width in mask bits shrinks as SEW grows: (8 >> vsew) * NrLanes.
    always_comb begin
        beat_shift = 2'd3 - 2'(vsew_q);
        beat_bits  = PntW'(NrLanes) << beat_shift;
        pnt_after  = pnt_q + beat_bits;
        rem_step   = (rem_q > vlen_t'(beat_bits)) ? vlen_t'(beat_bits) : rem_q;
        rem_after  = rem_q - rem_step;
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        strb_d      = strb_q;
        pnt_d       = pnt_q;
        rem_d       = rem_q;
        vsew_d      = vsew_q;
        zero_done_d = 1'b0;
        flush_done  = 1'b0;

        in_ready_o  = (state_q == ACCUM);
        out_valid_o = (state_q == FLUSH);
        out_data_o  = acc_q;
        out_strb_o  = strb_q;
        busy_o      = (state_q != IDLE);
        vrf_pnt_o   = pnt_q;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (vl_i == '0) begin
                        zero_done_d = 1'b1;
                    end else begin
                        rem_d   = vl_i;
                        vsew_d  = vsew_i;
                        acc_d   = '0;
                        strb_d  = '0;
                        pnt_d   = '0;
                        state_d = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (in_valid_i) begin
                    acc_d  = (acc_q & ~in_be_i) | (in_bits_i & in_be_i);
                    strb_d = strb_q | be_bytes;
                    pnt_d  = pnt_after;
                    rem_d  = rem_after;
                    if (pnt_after == PntW'(W) || rem_after == '0) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (out_ready_i) begin
                    if (rem_q == '0) begin
                        flush_done = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        acc_d   = '0;
                        strb_d  = '0;
                        pnt_d   = '0;
                        state_d = ACCUM;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A reset coinciding with the final acceptance suppresses the done pulse.
        done_o = (zero_done_q | flush_done) & ~rst_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            strb_q      <= '0;
            pnt_q       <= '0;
            rem_q       <= '0;
            vsew_q      <= EW8;
            zero_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            strb_q      <= strb_d;
            pnt_q       <= pnt_d;
            rem_q       <= rem_d;
            vsew_q      <= vsew_d;
            zero_done_q <= zero_done_d;
        end
    end

endmodule
